// File: rtl/motor_pkg.sv
// Shared types and field layout for the motor command sequencer.
package motor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_TURN,
      ST_PAUSE,
      ST_MOVE
   } state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Command word is {turn[TURN_W-1:0], move[MOVE_W-1:0]}; the turn MSB is direction.
   localparam int MOVE_LSB = 0;

   function automatic int turn_lsb(input int move_w);
      return move_w;
   endfunction

   function automatic int dir_pos(input int turn_w, input int move_w);
      return turn_w + move_w - 1;
   endfunction

   function automatic int soft_step(input int duty);
      if (duty <= 0) return 0;
      return (duty / 4 == 0) ? 1 : duty / 4;
   endfunction

endpackage

// File: rtl/motor_command_sequencer_if.sv
// Command ingress bundle between the main-FPGA command path and the sequencer.
interface motor_command_sequencer_if #(
   parameter int CMD_W = 12
);
   logic             command_ready;
   logic [CMD_W-1:0] command;
   logic             command_accept;
   logic             fifo_full;
   logic             overflow;

   modport master (
      output command_ready, command,
      input  command_accept, fifo_full, overflow
   );

   modport slave (
      input  command_ready, command,
      output command_accept, fifo_full, overflow
   );
endinterface

// File: rtl/motor_cmd_fifo.sv
// Small synchronous FIFO, one write and one read per cycle, full/empty from an occupancy count.
module motor_cmd_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   // Full is judged on the current count, so a push is refused even when a pop lands the same cycle.
   always_comb begin
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      mem_d    = mem_q;
      if (do_wr) mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d = wr_ptr_q + AW'(do_wr);
      rd_ptr_d = rd_ptr_q + AW'(do_rd);
      count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/motor_command_sequencer.sv
// Queued turn/pause/move sequencer driving PWM-gated motor enables.
// Define MOTOR_SOFT_START_EN to ramp the duty up in PWM_DUTY/4 steps on each TURN/MOVE entry.
module motor_command_sequencer
   import motor_pkg::*;
#(
   parameter int TURN_W      = 6,
   parameter int MOVE_W      = 6,
   parameter int UNIT_CYCLES = 50,
   parameter int PWM_PERIOD  = 16,
   parameter int PWM_DUTY    = 12,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   motor_command_sequencer_if.slave cmd_if,
   output logic                     busy,
   output logic                     done,
   output logic                     motor_l,
   output logic                     motor_r
);
   localparam int CMD_W    = TURN_W + MOVE_W;
   localparam int TMAG_W   = TURN_W - 1;
   localparam int UL_W     = (TMAG_W > MOVE_W) ? TMAG_W : MOVE_W;
   localparam int UC_W     = $clog2(UNIT_CYCLES);
   localparam int PC_W     = $clog2(PWM_PERIOD);
   localparam int DUTY_W   = $clog2(PWM_PERIOD + 1);
   localparam int TURN_LSB = turn_lsb(MOVE_W);
   localparam int DIR_POS  = dir_pos(TURN_W, MOVE_W);

   state_e            state_q, state_d;
   logic              ready_q, ready_d;
   logic              accept_q, accept_d;
   logic              overflow_q, overflow_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              motor_l_q, motor_l_d;
   logic              motor_r_q, motor_r_d;
   logic              turn_dir_q, turn_dir_d;
   logic [TMAG_W-1:0] turn_mag_q, turn_mag_d;
   logic [MOVE_W-1:0] move_mag_q, move_mag_d;
   logic [UC_W-1:0]   unit_cnt_q, unit_cnt_d;
   logic [UL_W-1:0]   units_q, units_d;
   logic [PC_W-1:0]   pwm_cnt_q, pwm_cnt_d;

   logic              rise, pop, fifo_full, fifo_empty;
   logic [CMD_W-1:0]  fifo_rdata;
   logic              unit_wrap, last_unit;
   logic              pwm_enter, pwm_wrap, pwm;
   logic [DUTY_W-1:0] eff_duty;

   assign rise = cmd_if.command_ready && !ready_q;
   assign pop  = (state_q == ST_IDLE) && !fifo_empty;

   motor_cmd_fifo #(
      .WIDTH(CMD_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clock),
      .rst_n  (reset),
      .wr_en  (rise),
      .wr_data(cmd_if.command),
      .rd_en  (pop),
      .rd_data(fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign unit_wrap = (unit_cnt_q == UC_W'(UNIT_CYCLES - 1));
   assign last_unit = unit_wrap && (units_q == UL_W'(1));

   always_comb begin
      state_d    = state_q;
      turn_dir_d = turn_dir_q;
      turn_mag_d = turn_mag_q;
      move_mag_d = move_mag_q;
      unit_cnt_d = unit_wrap ? '0 : unit_cnt_q + UC_W'(1);
      units_d    = units_q - UL_W'(unit_wrap);
      done_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            unit_cnt_d = '0;
            units_d    = units_q;
            if (pop) begin
               state_d    = ST_LOAD;
               turn_dir_d = fifo_rdata[DIR_POS];
               turn_mag_d = fifo_rdata[DIR_POS-1:TURN_LSB];
               move_mag_d = fifo_rdata[TURN_LSB-1:MOVE_LSB];
            end
         end
         ST_LOAD: begin
            unit_cnt_d = '0;
            if (turn_mag_q != '0) begin
               state_d = ST_TURN;
               units_d = UL_W'(turn_mag_q);
            end else if (move_mag_q != '0) begin
               state_d = ST_MOVE;
               units_d = UL_W'(move_mag_q);
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_TURN: begin
            if (last_unit) begin
               state_d = ST_PAUSE;
               units_d = UL_W'(1);
            end
         end
         ST_PAUSE: begin
            if (last_unit) begin
               if (move_mag_q != '0) begin
                  state_d = ST_MOVE;
                  units_d = UL_W'(move_mag_q);
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         ST_MOVE: begin
            if (last_unit) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // PWM phase restarts whenever a driving phase begins so the first active cycle is a high one.
   always_comb begin
      pwm_enter = ((state_d == ST_TURN) || (state_d == ST_MOVE)) && (state_d != state_q);
      pwm_wrap  = (pwm_cnt_q == PC_W'(PWM_PERIOD - 1));
      pwm_cnt_d = (pwm_enter || pwm_wrap) ? '0 : pwm_cnt_q + PC_W'(1);
      pwm       = (DUTY_W'(pwm_cnt_q) < eff_duty);
   end

`ifdef MOTOR_SOFT_START_EN
   localparam int STEP = soft_step(PWM_DUTY);

   logic [DUTY_W-1:0] duty_q, duty_d;

   always_comb begin
      duty_d = duty_q;
      if (pwm_enter) begin
         duty_d = DUTY_W'(STEP);
      end else if (pwm_wrap && (int'(duty_q) < PWM_DUTY)) begin
         duty_d = (int'(duty_q) + STEP >= PWM_DUTY) ? DUTY_W'(PWM_DUTY)
                                                    : DUTY_W'(int'(duty_q) + STEP);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) duty_q <= '0;
      else        duty_q <= duty_d;
   end

   assign eff_duty = duty_q;
`else
   assign eff_duty = DUTY_W'(PWM_DUTY);
`endif

   // Busy stays up one cycle past IDLE entry so it covers the final registered motor/done cycle.
   always_comb begin
      ready_d    = cmd_if.command_ready;
      accept_d   = rise && !fifo_full;
      overflow_d = overflow_q || (rise && fifo_full);
      busy_d     = (state_d != ST_IDLE) || (state_q != ST_IDLE);
      motor_l_d  = pwm && (((state_q == ST_TURN) && (turn_dir_q == DIR_RIGHT)) ||
                           (state_q == ST_MOVE));
      motor_r_d  = pwm && (((state_q == ST_TURN) && (turn_dir_q == DIR_LEFT)) ||
                           (state_q == ST_MOVE));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         accept_q   <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         motor_l_q  <= 1'b0;
         motor_r_q  <= 1'b0;
         turn_dir_q <= 1'b0;
         turn_mag_q <= '0;
         move_mag_q <= '0;
         unit_cnt_q <= '0;
         units_q    <= '0;
         pwm_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         accept_q   <= accept_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         motor_l_q  <= motor_l_d;
         motor_r_q  <= motor_r_d;
         turn_dir_q <= turn_dir_d;
         turn_mag_q <= turn_mag_d;
         move_mag_q <= move_mag_d;
         unit_cnt_q <= unit_cnt_d;
         units_q    <= units_d;
         pwm_cnt_q  <= pwm_cnt_d;
      end
   end

   assign cmd_if.command_accept = accept_q;
   assign cmd_if.fifo_full      = fifo_full;
   assign cmd_if.overflow       = overflow_q;
   assign busy                  = busy_q;
   assign done                  = done_q;
   assign motor_l               = motor_l_q;
   assign motor_r               = motor_r_q;
endmodule

// File: tb/tb_motor_command_sequencer.sv
// Bench for motor_command_sequencer: directed and randomized commands against a run-length reference model.
module tb_motor_command_sequencer;
   localparam int UC = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   motor_command_sequencer_if #(.CMD_W(12)) m_if ();
   motor_command_sequencer_if #(.CMD_W(12)) p_if ();

   logic busy, done, motor_l, motor_r;
   logic busy2, done2, ml2, mr2;

   motor_command_sequencer #(
      .TURN_W(6), .MOVE_W(6), .UNIT_CYCLES(UC), .PWM_PERIOD(4), .PWM_DUTY(4), .FIFO_DEPTH(4)
   ) u_dut (
      .clock(clk), .reset(rst_n), .cmd_if(m_if),
      .busy(busy), .done(done), .motor_l(motor_l), .motor_r(motor_r)
   );

   motor_command_sequencer #(
      .TURN_W(6), .MOVE_W(6), .UNIT_CYCLES(UC), .PWM_PERIOD(4), .PWM_DUTY(1), .FIFO_DEPTH(4)
   ) u_dut_pwm1 (
      .clock(clk), .reset(rst_n), .cmd_if(p_if),
      .busy(busy2), .done(done2), .motor_l(ml2), .motor_r(mr2)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_acc = 0, n_done = 0, n_busy = 0, n_hot = 0;
   int rc[$];
   int rl[$];
   logic [11:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected motor activity per command as runs of {motor_l,motor_r} codes.
   task automatic check_done();
      logic [11:0] c;
      int ec[$];
      int el[$];
      int t, m;
      while (rc.size() > 0 && rc[0] == 0) begin void'(rc.pop_front()); void'(rl.pop_front()); end
      while (rc.size() > 0 && rc[rc.size()-1] == 0) begin void'(rc.pop_back()); void'(rl.pop_back()); end
      chk("done_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         t = int'(c[10:6]);
         m = int'(c[5:0]);
         if (t > 0) begin
            ec.push_back(c[11] ? 1 : 2); el.push_back(t * UC);
            if (m > 0) begin ec.push_back(0); el.push_back(UC); end
         end
         if (m > 0) begin ec.push_back(3); el.push_back(m * UC); end
         chk($sformatf("cmd%03h_runs", c), rc.size(), ec.size());
         for (int i = 0; i < ec.size() && i < rc.size(); i++) begin
            chk($sformatf("cmd%03h_code%0d", c, i), rc[i], ec[i]);
            chk($sformatf("cmd%03h_len%0d", c, i), rl[i], el[i]);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         rc.delete();
         rl.delete();
      end else begin
         if (m_if.command_accept) n_acc++;
         if (busy) n_busy++;
         if (motor_l || motor_r) n_hot++;
         if (rc.size() > 0 && rc[rc.size()-1] == int'({motor_l, motor_r}))
            rl[rl.size()-1] = rl[rl.size()-1] + 1;
         else begin
            rc.push_back(int'({motor_l, motor_r}));
            rl.push_back(1);
         end
         if (done) begin
            n_done++;
            check_done();
            rc.delete();
            rl.delete();
         end
      end
   end

   task automatic push(input logic [11:0] c);
      @(posedge clk); #1;
      m_if.command = c;
      m_if.command_ready = 1'b1;
      @(posedge clk); #1;
      m_if.command_ready = 1'b0;
   endtask

   task automatic drain(input string tag);
      int i = 0;
      while (i < 3000 && (exp_q.size() != 0 || busy !== 1'b0)) begin
         @(posedge clk); #1;
         i++;
      end
      chk({tag, "_drained"}, exp_q.size(), 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   function automatic logic [11:0] rnd_cmd();
      logic [11:0] c;
      c       = '0;
      c[11]   = 1'($urandom_range(0, 1));
      c[10:6] = 5'($urandom_range(0, 3));
      c[5:0]  = 6'($urandom_range(0, 3));
      return c;
   endfunction

   initial begin
      int a0, a1, d0, b0, h0, k;
      logic [11:0] c;
      rst_n = 1'b0;
      m_if.command_ready = 1'b0; m_if.command = '0;
      p_if.command_ready = 1'b0; p_if.command = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_accept", m_if.command_accept, 0);
      chk("rst_full", m_if.fifo_full, 0);
      chk("rst_overflow", m_if.overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_motor_l", motor_l, 0);
      chk("rst_motor_r", motor_r, 0);
      rst_n = 1'b1;

      // Held-high ready must enqueue once.
      a0 = n_acc; d0 = n_done;
      exp_q.push_back(12'h104);
      @(posedge clk); #1;
      m_if.command = 12'h104;
      m_if.command_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1 m_if.command_ready = 1'b0;
      drain("t104");
      chk("t104_accepts", n_acc - a0, 1);
      chk("t104_dones", n_done - d0, 1);

      exp_q.push_back(12'h843);
      push(12'h843);
      drain("t843");

      a0 = n_acc; b0 = n_busy; h0 = n_hot;
      exp_q.push_back(12'h000);
      push(12'h000);
      drain("t000");
      repeat (3) @(posedge clk);
      chk("t000_accepts", n_acc - a0, 1);
      chk("t000_busy_cycles", n_busy - b0, 2);
      chk("t000_motors_quiet", n_hot - h0, 0);

      // Overflow: fill the queue behind a long command.
      d0 = n_done;
      exp_q.push_back(12'h104);
      push(12'h104);
      for (int i = 0; i < 20 && busy !== 1'b1; i++) @(posedge clk);
      #1;
      chk("ovf_busy", busy, 1);
      a1 = n_acc;
      for (int i = 0; i < 5; i++) begin
         c = rnd_cmd();
         if (i < 4) exp_q.push_back(c);
         push(c);
      end
      chk("ovf_accepts", n_acc - a1, 4);
      chk("ovf_full", m_if.fifo_full, 1);
      chk("ovf_flag", m_if.overflow, 1);
      drain("ovf");
      chk("ovf_dones", n_done - d0, 5);
      chk("ovf_full_after", m_if.fifo_full, 0);
      chk("ovf_sticky", m_if.overflow, 1);

      for (int r = 0; r < 6; r++) begin
         k = int'($urandom_range(1, 4));
         a0 = n_acc;
         for (int j = 0; j < k; j++) begin
            c = rnd_cmd();
            exp_q.push_back(c);
            push(c);
         end
         drain($sformatf("rnd%0d", r));
         chk($sformatf("rnd%0d_accepts", r), n_acc - a0, k);
      end

      // Duty of 1/4: one high cycle per PWM period through a 10-cycle MOVE.
      @(posedge clk); #1;
      p_if.command = 12'h001;
      p_if.command_ready = 1'b1;
      @(posedge clk); #1;
      p_if.command_ready = 1'b0;
      for (int i = 0; i < 20 && ml2 !== 1'b1; i++) @(negedge clk);
      chk("pwm1_start", ml2, 1);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("pwm1_l%0d", i), ml2, (i % 4 == 0));
         chk($sformatf("pwm1_r%0d", i), mr2, (i % 4 == 0));
         chk($sformatf("pwm1_done%0d", i), done2, (i == 9));
         @(negedge clk);
      end
      chk("pwm1_off", ml2 | mr2, 0);
      chk("pwm1_done_once", done2, 0);

      // Reset mid-MOVE with two commands still queued.
      push(12'h00A);
      push(rnd_cmd());
      push(rnd_cmd());
      for (int i = 0; i < 200 && !(motor_l === 1'b1 && motor_r === 1'b1); i++) @(posedge clk);
      #2;
      chk("mid_move_active", motor_l & motor_r, 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("arst_motor_l", motor_l, 0);
      chk("arst_motor_r", motor_r, 0);
      chk("arst_busy", busy, 0);
      chk("arst_full", m_if.fifo_full, 0);
      chk("arst_overflow", m_if.overflow, 0);
      d0 = n_done; h0 = n_hot;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_busy", busy, 0);
      chk("post_rst_full", m_if.fifo_full, 0);
      chk("post_rst_overflow", m_if.overflow, 0);
      chk("post_rst_dones", n_done - d0, 0);
      chk("post_rst_motors", n_hot - h0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
